// File: rtl/otp_ctrl.sv
// OTP ROM front-end: boot-time shadow load, CPU read pass-through and checked 0->1 burn sequencing.
// Optional OTP_LOCK_EN: shadow word 0 bit 1 acts as a global burn lock once the shadows are loaded.
module otp_ctrl #(
  parameter int                   BUS_WIDTH   = 32,
  parameter int                   DATA_WIDTH  = 32,
  parameter int                   NUM_SHADOW  = 4,
  parameter logic [BUS_WIDTH-1:0] SHADOW_BASE = 'h10,
  parameter int                   PROG_CYCLES = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [BUS_WIDTH-1:0]             m_ram_raddr,
  output logic [DATA_WIDTH-1:0]            m_ram_rdata,
  input  logic                             m_ram_ren,
  input  logic [BUS_WIDTH-1:0]             m_ram_waddr,
  input  logic [DATA_WIDTH-1:0]            m_ram_wdata,
  input  logic [DATA_WIDTH/8-1:0]          m_ram_wen,
  output logic                             m_ram_busy,
  output logic [BUS_WIDTH-1:0]             s_ram_raddr,
  input  logic [DATA_WIDTH-1:0]            s_ram_rdata,
  output logic                             s_ram_ren,
  output logic [BUS_WIDTH-1:0]             s_ram_waddr,
  output logic [DATA_WIDTH-1:0]            s_ram_wdata,
  output logic [DATA_WIDTH/8-1:0]          s_ram_wen,
  output logic [NUM_SHADOW*DATA_WIDTH-1:0] shadow_words,
  output logic                             load_done,
  output logic                             secure_debug_disable,
  output logic                             prog_done,
  output logic                             prog_err
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(NUM_SHADOW + 1);
  localparam int CNT_W = $clog2(PROG_CYCLES + 1);
  localparam logic [BUS_WIDTH-1:0] WORD_BYTES = BUS_WIDTH'(BE_W);

  typedef enum logic [2:0] {LOAD, LOAD_LAST, IDLE, PROG_RD, PROG_CHK, PROG_WR} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [CNT_W-1:0]       cnt;
  logic [DATA_WIDTH-1:0]  shadow_q [NUM_SHADOW];
  logic [BUS_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [BE_W-1:0]        wen_q;
  logic                   lock;

  function automatic logic [DATA_WIDTH-1:0] expand_be(input logic [BE_W-1:0] be);
    logic [DATA_WIDTH-1:0] m;
    for (int b = 0; b < BE_W; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

  // A burn may only set bits; any enabled bit that is 1 now but 0 in the new data is illegal.
  function automatic logic burn_illegal(input logic [DATA_WIDTH-1:0] old,
                                        input logic [DATA_WIDTH-1:0] data,
                                        input logic [BE_W-1:0]       be);
    return |(old & ~data & expand_be(be));
  endfunction

`ifdef OTP_LOCK_EN
  assign lock = load_done & shadow_q[0][1];
`else
  assign lock = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      idx       <= '0;
      cnt       <= '0;
      load_done <= 1'b0;
      prog_done <= 1'b0;
      prog_err  <= 1'b0;
      for (int i = 0; i < NUM_SHADOW; i++) shadow_q[i] <= '0;
    end else begin
      prog_done <= 1'b0;
      case (state)
        LOAD, LOAD_LAST: begin
          // Read data lags the issued address by one cycle, so capture slot idx-1.
          for (int i = 0; i < NUM_SHADOW; i++)
            if (idx == IDX_W'(i + 1)) shadow_q[i] <= s_ram_rdata;
          if (state == LOAD_LAST) begin
            load_done <= 1'b1;
            state     <= IDLE;
          end else begin
            idx <= idx + 1'b1;
            if (idx == IDX_W'(NUM_SHADOW - 1)) state <= LOAD_LAST;
          end
        end
        IDLE: if (|m_ram_wen) state <= PROG_RD;
        PROG_RD: state <= PROG_CHK;
        PROG_CHK: begin
          if (lock || burn_illegal(s_ram_rdata, wdata_q, wen_q)) begin
            prog_err  <= 1'b1;
            prog_done <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt   <= '0;
            state <= PROG_WR;
          end
        end
        PROG_WR: begin
          if (cnt == CNT_W'(PROG_CYCLES - 1)) begin
            prog_done <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && |m_ram_wen) begin
      addr_q  <= m_ram_waddr;
      wdata_q <= m_ram_wdata;
      wen_q   <= m_ram_wen;
    end
  end

  always_comb begin
    s_ram_ren   = 1'b0;
    s_ram_raddr = '0;
    s_ram_waddr = '0;
    s_ram_wdata = '0;
    s_ram_wen   = '0;
    case (state)
      LOAD: begin
        s_ram_ren   = ~reset;
        s_ram_raddr = SHADOW_BASE + BUS_WIDTH'(idx) * WORD_BYTES;
      end
      IDLE: begin
        s_ram_ren   = m_ram_ren;
        s_ram_raddr = m_ram_raddr;
      end
      PROG_RD: begin
        s_ram_ren   = 1'b1;
        s_ram_raddr = addr_q;
      end
      PROG_WR: begin
        s_ram_waddr = addr_q;
        s_ram_wdata = wdata_q;
        s_ram_wen   = wen_q;
      end
      default: ;
    endcase
  end

  assign m_ram_busy           = (state != IDLE);
  assign m_ram_rdata          = s_ram_rdata;
  assign secure_debug_disable = ~load_done | shadow_q[0][0];

  for (genvar g = 0; g < NUM_SHADOW; g++) begin : g_shadow
    assign shadow_words[g*DATA_WIDTH +: DATA_WIDTH] = shadow_q[g];
  end

endmodule

// File: tb/tb_otp_ctrl.sv
// Directed bench for otp_ctrl with a behavioural OTP ROM (1-cycle read latency, bits only burn to 1).
module tb_otp_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  m_ram_raddr, m_ram_waddr, m_ram_wdata, m_ram_rdata;
  logic         m_ram_ren, m_ram_busy;
  logic [3:0]   m_ram_wen;
  logic [31:0]  s_ram_raddr, s_ram_waddr, s_ram_wdata;
  logic [31:0]  otp_rdata;
  logic         s_ram_ren;
  logic [3:0]   s_ram_wen;
  logic [127:0] shadow_words;
  logic         load_done, secure_debug_disable, prog_done, prog_err;

  int checks = 0;
  int errors = 0;

  logic        poke_en = 1'b0;
  logic [31:0] poke_addr, poke_data;
  logic [31:0] mem [64];

  int   b_busy, b_wen;
  logic b_wr_ok, b_rd_ok, b_early_done;
  logic [31:0] rd;

  always #5 clk = ~clk;

  otp_ctrl dut (
    .clk(clk), .reset(reset),
    .m_ram_raddr(m_ram_raddr), .m_ram_rdata(m_ram_rdata), .m_ram_ren(m_ram_ren),
    .m_ram_waddr(m_ram_waddr), .m_ram_wdata(m_ram_wdata), .m_ram_wen(m_ram_wen),
    .m_ram_busy(m_ram_busy),
    .s_ram_raddr(s_ram_raddr), .s_ram_rdata(otp_rdata), .s_ram_ren(s_ram_ren),
    .s_ram_waddr(s_ram_waddr), .s_ram_wdata(s_ram_wdata), .s_ram_wen(s_ram_wen),
    .shadow_words(shadow_words), .load_done(load_done),
    .secure_debug_disable(secure_debug_disable),
    .prog_done(prog_done), .prog_err(prog_err)
  );

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr[7:2]] <= poke_data;
    if (s_ram_ren) otp_rdata <= mem[s_ram_raddr[7:2]];
    if (s_ram_wen != 4'h0)
      mem[s_ram_waddr[7:2]] <= mem[s_ram_waddr[7:2]] | (s_ram_wdata & be_mask(s_ram_wen));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    poke_en = 1'b1; poke_addr = addr; poke_data = data;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic read_word(input logic [31:0] addr);
    m_ram_raddr = addr; m_ram_ren = 1'b1;
    tick();
    m_ram_ren = 1'b0;
    #1;
    rd = m_ram_rdata;
  endtask

  // Presents one burn request, then walks the busy window collecting strobe statistics.
  task automatic do_burn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    m_ram_waddr = addr; m_ram_wdata = data; m_ram_wen = be;
    tick();
    m_ram_wen = 4'h0;
    b_busy = 0; b_wen = 0; b_wr_ok = 1'b1; b_rd_ok = 1'b0; b_early_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!m_ram_busy) break;
      if (k == 0) b_rd_ok = s_ram_ren && (s_ram_raddr == addr);
      b_busy++;
      if (s_ram_wen != 4'h0) begin
        b_wen++;
        if (s_ram_wen !== be || s_ram_waddr !== addr || s_ram_wdata !== data) b_wr_ok = 1'b0;
      end
      if (prog_done) b_early_done = 1'b1;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    m_ram_raddr = '0; m_ram_ren = 1'b0; m_ram_waddr = '0; m_ram_wdata = '0; m_ram_wen = '0;
    poke_addr = '0; poke_data = '0;
    tick(); tick();
    poke(32'h10, 32'h1);
    poke(32'h14, 32'hA5);
    poke(32'h18, 32'h0);
    poke(32'h1C, 32'hFFFF_FFFF);
    poke(32'h40, 32'hF0);
    poke(32'h44, 32'hF0);
    poke(32'h48, 32'h0);
    poke(32'h4C, 32'h0);
    #1;
    check("rst_busy", m_ram_busy, 1);
    check("rst_sdd", secure_debug_disable, 1);
    check("rst_ren", s_ram_ren, 0);
    check("rst_wen", s_ram_wen, 0);
    check("rst_load_done", load_done, 0);
    check("rst_prog_done", prog_done, 0);
    check("rst_prog_err", prog_err, 0);
    check("rst_shadow", shadow_words, 0);

    // Boot load: cycles 0..3 issue reads, cycle 4 captures the last word, cycle 5 is IDLE.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("boot_ren_%0d", i), s_ram_ren, 1);
      check($sformatf("boot_raddr_%0d", i), s_ram_raddr, 32'h10 + 4 * i);
      check($sformatf("boot_busy_%0d", i), m_ram_busy, 1);
      check($sformatf("boot_sdd_%0d", i), secure_debug_disable, 1);
      check($sformatf("boot_ldone_%0d", i), load_done, 0);
      tick();
    end
    #1;
    check("boot_last_ren", s_ram_ren, 0);
    check("boot_last_busy", m_ram_busy, 1);
    check("boot_last_ldone", load_done, 0);
    tick(); #1;
    check("boot_ldone", load_done, 1);
    check("boot_idle_busy", m_ram_busy, 0);
    check("boot_sdd", secure_debug_disable, 1);
    check("boot_shadow", shadow_words, {32'hFFFF_FFFF, 32'h0, 32'hA5, 32'h1});

    // CPU read pass-through.
    m_ram_raddr = 32'h40; m_ram_ren = 1'b1; #1;
    check("rd_fwd_ren", s_ram_ren, 1);
    check("rd_fwd_raddr", s_ram_raddr, 32'h40);
    tick(); m_ram_ren = 1'b0; #1;
    check("rd_data_40", m_ram_rdata, 32'hF0);

    // Legal burn F0 -> F3.
    do_burn(32'h40, 32'hF3, 4'hF);
    check("legal_idle", m_ram_busy, 0);
    check("legal_req_to_idle", b_busy + 1, 11);
    check("legal_rd_issue", b_rd_ok, 1);
    check("legal_wen_cycles", b_wen, 8);
    check("legal_wr_fields", b_wr_ok, 1);
    check("legal_no_early_done", b_early_done, 0);
    check("legal_prog_done", prog_done, 1);
    check("legal_prog_err", prog_err, 0);
    tick(); #1;
    check("legal_done_pulse_end", prog_done, 0);
    read_word(32'h40);
    check("legal_reread", rd, 32'hF3);

    // Illegal burn: byte 0 would clear bits 7:4.
    do_burn(32'h44, 32'h0F, 4'h1);
    check("illegal_idle", m_ram_busy, 0);
    check("illegal_busy", b_busy, 2);
    check("illegal_no_wen", b_wen, 0);
    check("illegal_prog_done", prog_done, 1);
    check("illegal_prog_err", prog_err, 1);
    tick(); #1;

    // Same data, byte 0 masked out: accepted.
    do_burn(32'h44, 32'h0F, 4'h2);
    check("masked_wen_cycles", b_wen, 8);
    check("masked_wr_fields", b_wr_ok, 1);
    check("masked_prog_done", prog_done, 1);
    check("masked_err_sticky", prog_err, 1);
    tick();
    read_word(32'h44);
    check("masked_reread", rd, 32'hF0);

    // Re-burning identical data still issues the strobe.
    tick();
    do_burn(32'h40, 32'hF3, 4'hF);
    check("same_wen_cycles", b_wen, 8);
    check("same_prog_done", prog_done, 1);
    tick();

    // Reset in the third PROG_WR cycle.
    m_ram_waddr = 32'h48; m_ram_wdata = 32'h1; m_ram_wen = 4'h1;
    tick(); m_ram_wen = 4'h0;
    tick(); tick(); tick(); tick(); #1;
    check("midrst_wr3_wen", s_ram_wen, 4'h1);
    reset = 1'b1;
    tick(); #1;
    check("midrst_wen_drop", s_ram_wen, 0);
    check("midrst_busy", m_ram_busy, 1);
    check("midrst_ldone", load_done, 0);
    check("midrst_prog_err", prog_err, 0);
    check("midrst_shadow", shadow_words, 0);
    poke(32'h10, 32'h0);
    reset = 1'b0; #1;
    check("reload_ren", s_ram_ren, 1);
    check("reload_raddr", s_ram_raddr, 32'h10);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("dbg_sdd_%0d", i), secure_debug_disable, 1);
      tick(); #1;
    end
    check("dbg_ldone", load_done, 1);
    check("dbg_sdd_open", secure_debug_disable, 0);
    check("dbg_shadow", shadow_words, {32'hFFFF_FFFF, 32'h0, 32'hA5, 32'h0});

`ifdef OTP_LOCK_EN
    reset = 1'b1;
    tick();
    poke(32'h10, 32'h2);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    #1;
    check("lock_ldone", load_done, 1);
    do_burn(32'h4C, 32'h1, 4'hF);
    check("lock_busy", b_busy, 2);
    check("lock_no_wen", b_wen, 0);
    check("lock_prog_done", prog_done, 1);
    check("lock_prog_err", prog_err, 1);
    tick();
    read_word(32'h40);
    check("lock_read", rd, 32'hF3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
